// File: rtl/mmm_pkg.sv
// Shared types for the branch unit front end: request payload, branch
// encodings and the arbiter FSM state.
package mmm_pkg;

  localparam int XLEN     = 32;
  localparam int B_IMM    = 13;
  localparam int BU_N_REQ = 2;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'd0,
    BR_BNE  = 3'd1,
    BR_BLT  = 3'd2,
    BR_BGE  = 3'd3,
    BR_BLTU = 3'd4,
    BR_BGEU = 3'd5,
    BR_JAL  = 3'd6,
    BR_JALR = 3'd7
  } branch_type_t;

  typedef struct packed {
    logic            taken;
    logic [XLEN-1:0] target;
  } prediction_t;

  // 'type' is a reserved word, so the branch kind lives in br_type.
  typedef struct packed {
    logic [XLEN-1:0]  rs1;
    logic [XLEN-1:0]  rs2;
    logic [B_IMM-1:0] imm;
    prediction_t      pred;
    branch_type_t     br_type;
  } bu_req_t;

  typedef enum logic {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
    return (id == n - 1) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/branch_unit_arbiter_rr.sv
// Combinational round-robin pick: first valid requester at or after the
// pointer, wrapping modulo N_REQ.
module branch_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  id_o,
  output logic             any_o
);

  int w_idx;

  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    w_idx = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[w_idx]) begin
        any_o        = 1'b1;
        gnt_o[w_idx] = 1'b1;
        id_o         = ID_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/branch_unit_arbiter.sv
// Shares one branch unit between N_REQ issue requesters: round-robin grant,
// grant hold while the unit stalls, and owner tagging of the next-cycle result.
module branch_unit_arbiter
  import mmm_pkg::*;
#(
  parameter int N_REQ = BU_N_REQ,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic [N_REQ-1:0] req_valid_i,
  input  bu_req_t          req_i [N_REQ],
  output logic [N_REQ-1:0] req_ready_o,
  output logic             bu_ops_valid_o,
  output bu_req_t          bu_req_o,
  input  logic             bu_ops_ready_i,
  output logic             res_valid_o,
  output logic [ID_W-1:0]  res_id_o,
  output arb_state_t       dbg_state_o,
  output logic [ID_W-1:0]  dbg_ptr_o
);

  // Handshake: an operation transfers to the branch unit in a cycle where
  // bu_ops_valid_o and bu_ops_ready_i are both high; the owning requester
  // sees req_ready_o in that same cycle. Once offered, the choice of requester
  // and its payload stay fixed until that transfer or a flush.

  arb_state_t        r_state;
  logic [ID_W-1:0]   r_ptr;
  logic [ID_W-1:0]   r_gnt_id;
  logic              r_infl;
  logic [ID_W-1:0]   r_infl_id;

  logic [N_REQ-1:0]  w_arb_gnt;
  logic [ID_W-1:0]   w_arb_id;
  logic              w_arb_any;
  logic [N_REQ-1:0]  w_hold_gnt;
  logic [N_REQ-1:0]  w_grant;
  logic [ID_W-1:0]   w_winner;
  logic              w_live;
  logic              w_acc;

  branch_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .req_i (req_valid_i),
    .ptr_i (r_ptr),
    .gnt_o (w_arb_gnt),
    .id_o  (w_arb_id),
    .any_o (w_arb_any)
  );

  always_comb begin
    w_hold_gnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_hold_gnt[i] = (r_gnt_id == ID_W'(i));
    end
  end

  // Reset is folded into w_live so outputs drop the instant rst_n_i falls,
  // not just at the next clock.
  assign w_live         = rst_n_i & ~flush_i;
  assign w_grant        = (r_state == HOLD) ? w_hold_gnt : w_arb_gnt;
  assign w_winner       = (r_state == HOLD) ? r_gnt_id : w_arb_id;
  assign bu_ops_valid_o = w_live & ((r_state == HOLD) | w_arb_any);
  assign w_acc          = bu_ops_valid_o & bu_ops_ready_i;
  assign req_ready_o    = w_grant & {N_REQ{bu_ops_ready_i & w_live}};

  always_comb begin
    bu_req_o = req_i[0];
    for (int i = 1; i < N_REQ; i++) begin
      if (w_winner == ID_W'(i)) begin
        bu_req_o = req_i[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= ARB;
      r_ptr     <= '0;
      r_gnt_id  <= '0;
      r_infl    <= 1'b0;
      r_infl_id <= '0;
    end else begin
      r_infl <= w_acc;
      if (w_acc) begin
        r_infl_id <= w_winner;
        r_ptr     <= ID_W'(rr_next(int'(w_winner), N_REQ));
      end
      case (r_state)
        ARB: begin
          if (w_arb_any && !w_acc && !flush_i) begin
            r_state  <= HOLD;
            r_gnt_id <= w_arb_id;
          end
        end
        HOLD: begin
          if (flush_i || w_acc) begin
            r_state <= ARB;
          end
        end
        default: r_state <= ARB;
      endcase
    end
  end

  assign res_valid_o = r_infl & ~flush_i;
  assign res_id_o    = r_infl_id;
  assign dbg_state_o = r_state;
  assign dbg_ptr_o   = r_ptr;

endmodule

// File: tb/tb_branch_unit_arbiter.sv
// Directed bench for branch_unit_arbiter: a 2-requester instance for the main
// scenarios and a 4-requester instance for pointer wrap-around.
module tb_branch_unit_arbiter;
  import mmm_pkg::*;

  logic       clk;
  logic       rst_n;

  logic       flush2, ready2;
  logic [1:0] vld2;
  bu_req_t    req2 [2];
  logic [1:0] rdy2;
  logic       ov2;
  bu_req_t    bureq2;
  logic       rv2;
  logic [0:0] rid2;
  arb_state_t st2;
  logic [0:0] ptr2;

  logic       flush4, ready4;
  logic [3:0] vld4;
  bu_req_t    req4 [4];
  logic [3:0] rdy4;
  logic       ov4;
  bu_req_t    bureq4;
  logic       rv4;
  logic [1:0] rid4;
  arb_state_t st4;
  logic [1:0] ptr4;

  int n_checks = 0;
  int n_fail   = 0;

  branch_unit_arbiter #(.N_REQ(2)) dut2 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush2),
    .req_valid_i(vld2), .req_i(req2), .req_ready_o(rdy2),
    .bu_ops_valid_o(ov2), .bu_req_o(bureq2), .bu_ops_ready_i(ready2),
    .res_valid_o(rv2), .res_id_o(rid2),
    .dbg_state_o(st2), .dbg_ptr_o(ptr2)
  );

  branch_unit_arbiter #(.N_REQ(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush4),
    .req_valid_i(vld4), .req_i(req4), .req_ready_o(rdy4),
    .bu_ops_valid_o(ov4), .bu_req_o(bureq4), .bu_ops_ready_i(ready4),
    .res_valid_o(rv4), .res_id_o(rid4),
    .dbg_state_o(st4), .dbg_ptr_o(ptr4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush2 = 1'b0; ready2 = 1'b1; vld2 = 2'b11;
    flush4 = 1'b0; ready4 = 1'b1; vld4 = 4'b1111;
    #12;
    n_checks++; if (ov2 !== 1'b0) begin n_fail++; $display("FAIL reset_ops_valid: got %b expected 0", ov2); end
    n_checks++; if (rdy2 !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", rdy2); end
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", rv2); end
    n_checks++; if (rid2 !== 1'b0) begin n_fail++; $display("FAIL reset_res_id: got %0d expected 0", rid2); end
    n_checks++; if (st2 !== ARB) begin n_fail++; $display("FAIL reset_state: got %0d expected ARB", st2); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset_ops_valid4: got %b expected 0", ov4); end
    @(negedge clk);
    vld2 = 2'b00; vld4 = 4'b0000; ready4 = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g;
    logic       exp_id;
    step();
    vld2 = 2'b11; ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_g  = (k % 2 == 0) ? 2'b01 : 2'b10;
      exp_id = 1'((k + 1) % 2);
      n_checks++; if (rdy2 !== exp_g) begin n_fail++; $display("FAIL contention_grant k=%0d: got %b expected %b", k, rdy2, exp_g); end
      n_checks++; if (rv2 !== (k > 0)) begin n_fail++; $display("FAIL contention_res_valid k=%0d: got %b expected %b", k, rv2, (k > 0)); end
      if (k > 0) begin
        n_checks++; if (rid2 !== exp_id) begin n_fail++; $display("FAIL contention_res_id k=%0d: got %0d expected %0d", k, rid2, exp_id); end
      end
      step();
    end
    vld2 = 2'b00;
    #1;
    n_checks++; if (rv2 !== 1'b1 || rid2 !== 1'b1) begin n_fail++; $display("FAIL contention_last_res: got v=%b id=%0d expected v=1 id=1", rv2, rid2); end
    step();
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL contention_res_drop: got %b expected 0", rv2); end
    n_checks++; if (ptr2 !== 1'b0) begin n_fail++; $display("FAIL contention_ptr: got %0d expected 0", ptr2); end
  endtask

  task automatic test_stall_hold();
    step();
    vld2 = 2'b10; ready2 = 1'b0;
    #1;
    n_checks++; if (ov2 !== 1'b1 || rdy2 !== 2'b00) begin n_fail++; $display("FAIL stall_offer: got v=%b rdy=%b expected v=1 rdy=00", ov2, rdy2); end
    n_checks++; if (bureq2 !== req2[1]) begin n_fail++; $display("FAIL stall_payload0: got rs1=%h expected rs1=%h", bureq2.rs1, req2[1].rs1); end
    step();
    vld2 = 2'b11;
    #1;
    n_checks++; if (st2 !== HOLD) begin n_fail++; $display("FAIL stall_state: got %0d expected HOLD", st2); end
    n_checks++; if (bureq2 !== req2[1] || ov2 !== 1'b1) begin n_fail++; $display("FAIL stall_payload1: got rs1=%h v=%b expected rs1=%h v=1", bureq2.rs1, ov2, req2[1].rs1); end
    step();
    #1;
    n_checks++; if (bureq2 !== req2[1] || rdy2 !== 2'b00) begin n_fail++; $display("FAIL stall_payload2: got rs1=%h rdy=%b expected rs1=%h rdy=00", bureq2.rs1, rdy2, req2[1].rs1); end
    step();
    ready2 = 1'b1;
    #1;
    n_checks++; if (rdy2 !== 2'b10) begin n_fail++; $display("FAIL stall_release: got %b expected 10", rdy2); end
    step();
    vld2 = 2'b01;
    #1;
    n_checks++; if (rdy2 !== 2'b01 || st2 !== ARB) begin n_fail++; $display("FAIL stall_next: got rdy=%b st=%0d expected rdy=01 st=ARB", rdy2, st2); end
    n_checks++; if (rv2 !== 1'b1 || rid2 !== 1'b1) begin n_fail++; $display("FAIL stall_res1: got v=%b id=%0d expected v=1 id=1", rv2, rid2); end
    step();
    vld2 = 2'b00;
    #1;
    n_checks++; if (rv2 !== 1'b1 || rid2 !== 1'b0) begin n_fail++; $display("FAIL stall_res0: got v=%b id=%0d expected v=1 id=0", rv2, rid2); end
  endtask

  task automatic test_flush_result();
    step();
    vld2 = 2'b10; ready2 = 1'b1;
    #1;
    n_checks++; if (rdy2 !== 2'b10) begin n_fail++; $display("FAIL flushres_accept: got %b expected 10", rdy2); end
    step();
    vld2 = 2'b00; flush2 = 1'b1;
    #1;
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL flushres_res_valid: got %b expected 0", rv2); end
    step();
    flush2 = 1'b0;
    #1;
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL flushres_after: got %b expected 0", rv2); end
    n_checks++; if (ptr2 !== 1'b0) begin n_fail++; $display("FAIL flushres_ptr: got %0d expected 0", ptr2); end
  endtask

  task automatic test_flush_hold();
    step();
    vld2 = 2'b01; ready2 = 1'b0;
    #1;
    n_checks++; if (ov2 !== 1'b1 || rdy2 !== 2'b00) begin n_fail++; $display("FAIL flushhold_offer: got v=%b rdy=%b expected v=1 rdy=00", ov2, rdy2); end
    step();
    #1;
    n_checks++; if (st2 !== HOLD) begin n_fail++; $display("FAIL flushhold_state: got %0d expected HOLD", st2); end
    flush2 = 1'b1; ready2 = 1'b1;
    #1;
    n_checks++; if (ov2 !== 1'b0 || rdy2 !== 2'b00) begin n_fail++; $display("FAIL flushhold_mask: got v=%b rdy=%b expected v=0 rdy=00", ov2, rdy2); end
    step();
    flush2 = 1'b0; ready2 = 1'b0;
    #1;
    n_checks++; if (st2 !== ARB) begin n_fail++; $display("FAIL flushhold_rearb: got %0d expected ARB", st2); end
    n_checks++; if (ptr2 !== 1'b0) begin n_fail++; $display("FAIL flushhold_ptr: got %0d expected 0", ptr2); end
    ready2 = 1'b1;
    #1;
    n_checks++; if (rdy2 !== 2'b01) begin n_fail++; $display("FAIL flushhold_regrant: got %b expected 01", rdy2); end
    step();
    vld2 = 2'b00;
  endtask

  task automatic test_async_reset();
    step();
    vld2 = 2'b10; ready2 = 1'b0;
    step();
    #1;
    n_checks++; if (st2 !== HOLD) begin n_fail++; $display("FAIL areset_hold: got %0d expected HOLD", st2); end
    #2;
    rst_n = 1'b0; ready2 = 1'b1;
    #1;
    n_checks++; if (ov2 !== 1'b0 || rdy2 !== 2'b00) begin n_fail++; $display("FAIL areset_outputs: got v=%b rdy=%b expected v=0 rdy=00", ov2, rdy2); end
    n_checks++; if (rv2 !== 1'b0 || rid2 !== 1'b0) begin n_fail++; $display("FAIL areset_res: got v=%b id=%0d expected v=0 id=0", rv2, rid2); end
    n_checks++; if (st2 !== ARB || ptr2 !== 1'b0) begin n_fail++; $display("FAIL areset_regs: got st=%0d ptr=%0d expected ARB 0", st2, ptr2); end
    step();
    n_checks++; if (ov2 !== 1'b0 || rv2 !== 1'b0) begin n_fail++; $display("FAIL areset_held: got v=%b rv=%b expected 0 0", ov2, rv2); end
    #2;
    rst_n = 1'b1;
    #1;
    n_checks++; if (rdy2 !== 2'b10 || ov2 !== 1'b1) begin n_fail++; $display("FAIL areset_first_grant: got rdy=%b v=%b expected rdy=10 v=1", rdy2, ov2); end
    step();
    vld2 = 2'b00;
    #1;
    n_checks++; if (rv2 !== 1'b1 || rid2 !== 1'b1) begin n_fail++; $display("FAIL areset_res_after: got v=%b id=%0d expected v=1 id=1", rv2, rid2); end
    step();
    n_checks++; if (rv2 !== 1'b0) begin n_fail++; $display("FAIL areset_res_drop: got %b expected 0", rv2); end
  endtask

  task automatic test_wrap_around();
    logic [3:0] g_tab [3];
    logic [1:0] p_tab [3];
    logic [1:0] id_tab [3];
    g_tab  = '{4'b1000, 4'b0001, 4'b1000};
    p_tab  = '{2'd0, 2'd1, 2'd0};
    id_tab = '{2'd2, 2'd3, 2'd0};
    step();
    vld4 = 4'b0100; ready4 = 1'b1;
    #1;
    n_checks++; if (rdy4 !== 4'b0100) begin n_fail++; $display("FAIL wrap_setup: got %b expected 0100", rdy4); end
    step();
    vld4 = 4'b1001;
    n_checks++; if (ptr4 !== 2'd3) begin n_fail++; $display("FAIL wrap_ptr_start: got %0d expected 3", ptr4); end
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++; if (rdy4 !== g_tab[k]) begin n_fail++; $display("FAIL wrap_grant k=%0d: got %b expected %b", k, rdy4, g_tab[k]); end
      n_checks++; if (rv4 !== 1'b1 || rid4 !== id_tab[k]) begin n_fail++; $display("FAIL wrap_res k=%0d: got v=%b id=%0d expected v=1 id=%0d", k, rv4, rid4, id_tab[k]); end
      step();
      n_checks++; if (ptr4 !== p_tab[k]) begin n_fail++; $display("FAIL wrap_ptr k=%0d: got %0d expected %0d", k, ptr4, p_tab[k]); end
    end
    vld4 = 4'b0000;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      req2[i].rs1     = 32'hA000_0000 | 32'(i);
      req2[i].rs2     = 32'hB000_0000 | 32'(i);
      req2[i].imm     = 13'(16 + i);
      req2[i].pred    = '{taken: i[0], target: 32'hC000_0000 | 32'(i)};
      req2[i].br_type = branch_type_t'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      req4[i].rs1     = 32'hD000_0000 | 32'(i);
      req4[i].rs2     = 32'hE000_0000 | 32'(i);
      req4[i].imm     = 13'(32 + i);
      req4[i].pred    = '{taken: i[0], target: 32'hF000_0000 | 32'(i)};
      req4[i].br_type = branch_type_t'(i);
    end
    test_reset();
    test_contention();
    test_stall_hold();
    test_flush_result();
    test_flush_hold();
    test_async_reset();
    test_wrap_around();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
